// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : cache-side request/fill bus and memory-side port bundle
// Revision 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_grant;
    logic              i_fill_valid;
    logic              i_done;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_grant;
    logic              d_fill_valid;
    logic              d_done;

    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] fill_data;

    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
               mem_data_out, mem_data_valid,
        output i_grant, i_fill_valid, i_done,
               d_grant, d_fill_valid, d_done,
               fill_idx, fill_data,
               mem_enable, mem_wr, mem_addr, mem_data_in
    );

    // Caches plus memory side
    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
               mem_data_out, mem_data_valid,
        input  i_grant, i_fill_valid, i_done,
               d_grant, d_fill_valid, d_done,
               fill_idx, fill_data,
               mem_enable, mem_wr, mem_addr, mem_data_in
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one multi-cycle memory between ICACHE fills and DCACHE
//               fills / write-through stores. Optional MEM_ARB_ROUND_ROBIN_EN.
// Revision 1.0
// ============================================================================
module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int IDX_W           = 3,
    parameter int ADDR_W          = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int OFF_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] c_off_mask = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_I_FILL  = 2'd1,
        ST_D_FILL  = 2'd2,
        ST_D_WRITE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W:0]    iss_q, iss_d;
    logic [IDX_W-1:0]  rcv_q, rcv_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              i_first;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = DCACHE was served last; reset value makes ICACHE win the first tie.
    logic last_owner_q, last_owner_d;
    assign i_first = last_owner_q;
`else
    assign i_first = 1'b1;
`endif

    logic in_fill, issuing, last_valid;
    assign in_fill    = (state_q == ST_I_FILL) || (state_q == ST_D_FILL);
    assign issuing    = in_fill && !iss_q[IDX_W];
    assign last_valid = in_fill && bus.mem_data_valid && (rcv_q == c_last_idx);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        iss_d   = iss_q;
        rcv_d   = rcv_q;
        wdata_d = wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            ST_IDLE: begin
                iss_d = '0;
                rcv_d = '0;
                if (bus.i_req && (i_first || !bus.d_req)) begin
                    state_d = ST_I_FILL;
                    base_d  = bus.i_addr & ~c_off_mask;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_owner_d = 1'b0;
`endif
                end else if (bus.d_req) begin
                    if (bus.d_wr) begin
                        state_d = ST_D_WRITE;
                        base_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                    end else begin
                        state_d = ST_D_FILL;
                        base_d  = bus.d_addr & ~c_off_mask;
                    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_owner_d = 1'b1;
`endif
                end
            end
            ST_I_FILL, ST_D_FILL: begin
                if (!iss_q[IDX_W]) begin
                    iss_d = iss_q + (IDX_W+1)'(1);
                end
                // Latency-agnostic: completion is purely the count of returned words.
                if (bus.mem_data_valid) begin
                    rcv_d = rcv_q + IDX_W'(1);
                    if (rcv_q == c_last_idx) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_D_WRITE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            iss_q   <= '0;
            rcv_q   <= '0;
            wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            iss_q   <= iss_d;
            rcv_q   <= rcv_d;
            wdata_q <= wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign bus.i_grant      = (state_q == ST_I_FILL);
    assign bus.d_grant      = (state_q == ST_D_FILL) || (state_q == ST_D_WRITE);
    assign bus.i_fill_valid = (state_q == ST_I_FILL) && bus.mem_data_valid;
    assign bus.d_fill_valid = (state_q == ST_D_FILL) && bus.mem_data_valid;
    assign bus.i_done       = (state_q == ST_I_FILL) && last_valid;
    assign bus.d_done       = ((state_q == ST_D_FILL) && last_valid) || (state_q == ST_D_WRITE);
    assign bus.fill_idx     = in_fill ? rcv_q : '0;
    assign bus.fill_data    = bus.mem_data_out;

    assign bus.mem_enable   = issuing || (state_q == ST_D_WRITE);
    assign bus.mem_wr       = (state_q == ST_D_WRITE);
    assign bus.mem_addr     = (state_q == ST_D_WRITE) ? base_q :
                              issuing ? (base_q + ADDR_W'({iss_q[IDX_W-1:0], 1'b0})) : '0;
    assign bus.mem_data_in  = (state_q == ST_D_WRITE) ? wdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed bench with a latency/gap-programmable memory model
// Revision 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int LAT  = 4;
    localparam int NCYC = 4096;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.WORDS_PER_BLOCK(8), .IDX_W(3), .ADDR_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rc;

    // Memory model: response schedule indexed by absolute cycle
    logic        rv [NCYC];
    logic [15:0] rd [NCYC];
    int          last_resp = -1;
    int          n_iss;
    bit          gap_en = 1'b0;
    int          gap_tab [8] = '{0, 2, 0, 0, 5, 0, 1, 0};

    logic [15:0] issued [$];
    logic [2:0]  i_idx [$];
    logic [2:0]  d_idx [$];
    logic [15:0] i_dat [$];
    logic [15:0] d_dat [$];
    int i_done_n, d_done_n, i_done_cyc, d_done_cyc, i_gnt_first, d_gnt_first;
    int i_gnt_n, i_any_n, wr_n;
    int bad_n = 0;
    logic [15:0] wr_addr, wr_data;
    logic [2:0]  i_done_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        issued.delete(); i_idx.delete(); d_idx.delete(); i_dat.delete(); d_dat.delete();
        n_iss = 0; i_done_n = 0; d_done_n = 0; i_gnt_n = 0; i_any_n = 0; wr_n = 0;
        i_done_cyc = -1; d_done_cyc = -1; i_gnt_first = -1; d_gnt_first = -1;
        wr_addr = '0; wr_data = '0; i_done_idx = '0;
    endtask

    // Sample at the falling edge, then drive memory response after the rising edge.
    task automatic tick();
        bit drop_i = 1'b0;
        bit drop_d = 1'b0;
        int t;
        @(negedge clk);
        if (bus.mem_enable && !bus.mem_wr) begin
            t = cyc + LAT + (gap_en ? gap_tab[n_iss % 8] : 0);
            if (t <= last_resp) t = last_resp + 1;
            last_resp = t;
            if (t < NCYC) begin
                rv[t] = 1'b1;
                rd[t] = bus.mem_addr ^ 16'h5A5A;
            end
            issued.push_back(bus.mem_addr);
            n_iss++;
        end
        if (bus.mem_enable && bus.mem_wr) begin
            wr_n++; wr_addr = bus.mem_addr; wr_data = bus.mem_data_in;
        end
        if (bus.mem_wr && !(bus.d_grant && bus.d_done)) bad_n++;
        if (bus.mem_enable && !bus.i_grant && !bus.d_grant) bad_n++;
        if (bus.i_fill_valid) begin i_idx.push_back(bus.fill_idx); i_dat.push_back(bus.fill_data); end
        if (bus.d_fill_valid) begin d_idx.push_back(bus.fill_idx); d_dat.push_back(bus.fill_data); end
        if (bus.i_grant && i_gnt_first < 0) i_gnt_first = cyc;
        if (bus.d_grant && d_gnt_first < 0) d_gnt_first = cyc;
        if (bus.i_grant) i_gnt_n++;
        if (bus.i_grant || bus.i_fill_valid || bus.i_done) i_any_n++;
        if (bus.i_done) begin i_done_n++; i_done_cyc = cyc; i_done_idx = bus.fill_idx; drop_i = 1'b1; end
        if (bus.d_done) begin d_done_n++; d_done_cyc = cyc; drop_d = 1'b1; end
        @(posedge clk);
        #1;
        cyc++;
        if (drop_i) bus.i_req = 1'b0;
        if (drop_d) bus.d_req = 1'b0;
        bus.mem_data_valid = (cyc < NCYC) ? rv[cyc] : 1'b0;
        bus.mem_data_out   = (cyc < NCYC && rv[cyc]) ? rd[cyc] : 16'h0000;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_flags"}, 32'({bus.i_grant, bus.i_fill_valid, bus.i_done, bus.d_grant,
                                  bus.d_fill_valid, bus.d_done, bus.mem_enable, bus.mem_wr}), 32'h0);
        chk({tag, "_addr"},  32'(bus.mem_addr), 32'h0);
        chk({tag, "_wdata"}, 32'(bus.mem_data_in), 32'h0);
        chk({tag, "_idx"},   32'(bus.fill_idx), 32'h0);
    endtask

    // Checks a lone fill: 8 addresses, 8 indexed words, one done at done_rel.
    task automatic check_fill(input string tag, input logic [15:0] base, input bit is_i,
                              input int done_rel);
        chk({tag, "_iss_n"}, 32'(issued.size()), 32'd8);
        chk({tag, "_vld_n"}, 32'(is_i ? i_idx.size() : d_idx.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < issued.size())
                chk({tag, "_addr"}, 32'(issued[k]), 32'(base + 16'(2 * k)));
            if (is_i && k < i_idx.size()) begin
                chk({tag, "_idx"},  32'(i_idx[k]), 32'(k));
                chk({tag, "_data"}, 32'(i_dat[k]), 32'((base + 16'(2 * k)) ^ 16'h5A5A));
            end
            if (!is_i && k < d_idx.size()) begin
                chk({tag, "_idx"},  32'(d_idx[k]), 32'(k));
                chk({tag, "_data"}, 32'(d_dat[k]), 32'((base + 16'(2 * k)) ^ 16'h5A5A));
            end
        end
        chk({tag, "_done_n"},   32'(is_i ? i_done_n : d_done_n), 32'd1);
        chk({tag, "_done_cyc"}, 32'((is_i ? i_done_cyc : d_done_cyc) - rc), 32'(done_rel));
    endtask

    initial begin
        for (int k = 0; k < NCYC; k++) begin rv[k] = 1'b0; rd[k] = '0; end
        rst_n = 1'b0;
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_wr = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_data_out = '0; bus.mem_data_valid = 0;
        clear_logs();
        tick(); tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // ICACHE fill, latency 4
        clear_logs();
        bus.i_req = 1; bus.i_addr = 16'h123A; rc = cyc;
        repeat (16) tick();
        chk("ifill_grant_cyc", 32'(i_gnt_first - rc), 32'd1);
        chk("ifill_grant_len", 32'(i_gnt_n), 32'd12);
        chk("ifill_done_idx", 32'(i_done_idx), 32'd7);
        check_fill("ifill", 16'h1230, 1'b1, 12);
        chk("ifill_idle_after", 32'({bus.i_grant, bus.d_grant}), 32'h0);

        // DCACHE fill
        clear_logs();
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h0408; rc = cyc;
        repeat (16) tick();
        chk("dfill_grant_cyc", 32'(d_gnt_first - rc), 32'd1);
        chk("dfill_i_quiet", 32'(i_any_n), 32'd0);
        check_fill("dfill", 16'h0400, 1'b0, 12);

        // DCACHE write-through
        clear_logs();
        bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h2002; bus.d_wdata = 16'hBEEF; rc = cyc;
        repeat (4) tick();
        bus.d_wr = 0;
        chk("dwr_n", 32'(wr_n), 32'd1);
        chk("dwr_addr", 32'(wr_addr), 32'h2002);
        chk("dwr_data", 32'(wr_data), 32'hBEEF);
        chk("dwr_done_n", 32'(d_done_n), 32'd1);
        chk("dwr_done_cyc", 32'(d_done_cyc - rc), 32'd1);
        chk("dwr_no_fill", 32'(d_idx.size() + issued.size()), 32'd0);

        // Simultaneous requests: ICACHE first (last owner is DCACHE in either build)
        clear_logs();
        bus.i_req = 1; bus.i_addr = 16'h0100; bus.d_req = 1; bus.d_addr = 16'h0200; rc = cyc;
        repeat (30) tick();
        chk("both_i_grant", 32'(i_gnt_first - rc), 32'd1);
        chk("both_i_done", 32'(i_done_cyc - rc), 32'd12);
        chk("both_d_grant", 32'(d_gnt_first - rc), 32'd14);
        chk("both_d_done", 32'(d_done_cyc - rc), 32'd25);
        chk("both_iss_n", 32'(issued.size()), 32'd16);
        chk("both_addr8", 32'(issued[8]), 32'h0200);
        for (int k = 0; k < 8; k++)
            if (k < d_idx.size()) chk("both_d_idx", 32'(d_idx[k]), 32'(k));

`ifdef MEM_ARB_ROUND_ROBIN_EN
        // After an ICACHE-only fill, a tie goes to DCACHE
        clear_logs();
        bus.i_req = 1; bus.i_addr = 16'h0600;
        repeat (16) tick();
        clear_logs();
        bus.i_req = 1; bus.i_addr = 16'h0700; bus.d_req = 1; bus.d_addr = 16'h0800; rc = cyc;
        repeat (30) tick();
        chk("rr_d_grant", 32'(d_gnt_first - rc), 32'd1);
        chk("rr_i_grant", 32'(i_gnt_first - rc), 32'd14);
`endif

        // Reset in the middle of an ICACHE fill
        clear_logs();
        bus.i_req = 1; bus.i_addr = 16'h3000; rc = cyc;
        for (int n = 0; n < 30 && i_idx.size() < 3; n++) tick();
        chk("rst_reach_3", 32'(i_idx.size()), 32'd3);
        rst_n = 1'b0; bus.i_req = 0;
        #1;
        check_idle_outputs("rst_mid");
        tick(); tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("rst_vld_n", 32'(i_idx.size()), 32'd3);
        chk("rst_no_done", 32'(i_done_n), 32'd0);
        clear_logs();
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h0500; rc = cyc;
        repeat (16) tick();
        check_fill("rst_dfill", 16'h0500, 1'b0, 12);

        // Long ICACHE fill with irregular valid gaps; DCACHE waits behind it
        clear_logs();
        gap_en = 1'b1;
        bus.i_req = 1; bus.i_addr = 16'h401F; rc = cyc;
        tick();
        bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h5000;
        repeat (45) tick();
        gap_en = 1'b0;
        chk("gap_i_done", 32'(i_done_cyc - rc), 32'd17);
        chk("gap_i_vld_n", 32'(i_idx.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < i_idx.size()) begin
                chk("gap_i_idx", 32'(i_idx[k]), 32'(k));
                chk("gap_i_data", 32'(i_dat[k]), 32'((16'h4010 + 16'(2 * k)) ^ 16'h5A5A));
            end
        chk("gap_d_grant", 32'(d_gnt_first - rc), 32'd19);
        chk("gap_d_done", 32'(d_done_cyc - rc), 32'd35);

        chk("mem_strobe_rules", 32'(bad_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
